// File: rtl/mux_8to1_pkg.sv
// -----------------------------------------------------------------------------
// mux_8to1_pkg
// Shared constants and types for the registered 8-to-1 word multiplexer.
//   NUM_INPUTS    : number of selectable data words
//   SEL_W         : width of the select code
//   DEFAULT_WIDTH : default data word width
//   sel_t         : select code type
// -----------------------------------------------------------------------------
package mux_8to1_pkg;

  localparam int NUM_INPUTS    = 8;
  localparam int SEL_W         = 3;
  localparam int DEFAULT_WIDTH = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_8to1_pkg

// File: rtl/mux_8to1_core.sv
// -----------------------------------------------------------------------------
// mux_8to1_core
// Purely combinational 8:1 word select. Selection is positional:
// s=0 picks x1 ... s=7 picks x8. Every select code is a legal choice.
// Ports:
//   x1..x8   in  [WIDTH-1:0] data words
//   s        in  sel_t       select code
//   sel_word out [WIDTH-1:0] selected word
// -----------------------------------------------------------------------------
module mux_8to1_core
  import mux_8to1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  input  logic [WIDTH-1:0] x5,
  input  logic [WIDTH-1:0] x6,
  input  logic [WIDTH-1:0] x7,
  input  logic [WIDTH-1:0] x8,
  input  sel_t             s,
  output logic [WIDTH-1:0] sel_word
);

  // Full decode of all eight codes; the leading default only keeps the
  // block free of latches and is always overridden by one of the arms.
  always_comb begin
    sel_word = '0;
    case (s)
      3'd0: sel_word = x1;
      3'd1: sel_word = x2;
      3'd2: sel_word = x3;
      3'd3: sel_word = x4;
      3'd4: sel_word = x5;
      3'd5: sel_word = x6;
      3'd6: sel_word = x7;
      3'd7: sel_word = x8;
      default: sel_word = '0;
    endcase
  end

endmodule : mux_8to1_core

// File: rtl/mux_8to1_reg.sv
// -----------------------------------------------------------------------------
// mux_8to1_reg
// Registered 8-to-1 word multiplexer. The word picked by s is loaded into f
// on a rising clk edge when en is high; f_valid marks the cycle after each
// load. There is no combinational path from any input to f.
// Optional feature (macro MUX_8TO1_REG_PARITY_EN): adds f_par, the XOR
// reduction of the captured word, registered alongside f.
// Ports:
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset
//   en      in  capture enable
//   x1..x8  in  [WIDTH-1:0] data words (x1 selected by s=0)
//   s       in  [2:0] select code
//   f       out [WIDTH-1:0] registered selected word
//   f_valid out high for one cycle after each capture
//   f_par   out parity of f (only with MUX_8TO1_REG_PARITY_EN)
// -----------------------------------------------------------------------------
module mux_8to1_reg
  import mux_8to1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  input  logic [WIDTH-1:0] x5,
  input  logic [WIDTH-1:0] x6,
  input  logic [WIDTH-1:0] x7,
  input  logic [WIDTH-1:0] x8,
  input  logic [2:0]       s,
`ifdef MUX_8TO1_REG_PARITY_EN
  output logic             f_par,
`endif
  output logic [WIDTH-1:0] f,
  output logic             f_valid
);

  logic [WIDTH-1:0] sel_word;

  mux_8to1_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .x4      (x4),
    .x5      (x5),
    .x6      (x6),
    .x7      (x7),
    .x8      (x8),
    .s       (sel_t'(s)),
    .sel_word(sel_word)
  );

  // f holds its last value when en is low; f_valid simply follows en so a
  // continuously enabled stream keeps it high every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f       <= '0;
      f_valid <= 1'b0;
    end else begin
      f_valid <= en;
      if (en) begin
        f <= sel_word;
      end
    end
  end

`ifdef MUX_8TO1_REG_PARITY_EN
  // Parity is computed from the word being loaded so it always matches f.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_par <= 1'b0;
    end else if (en) begin
      f_par <= ^sel_word;
    end
  end
`endif

endmodule : mux_8to1_reg

// File: tb/tb_mux_8to1_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_8to1_reg
// Directed scoreboard bench for mux_8to1_reg. Each enabled vector pushes its
// expected word (and parity) into a queue; a monitor on the falling clock
// edge pops and compares whenever f_valid is high.
// -----------------------------------------------------------------------------
module tb_mux_8to1_reg;

  localparam int WIDTH = 3;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] f;
    logic             par;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] x1, x2, x3, x4, x5, x6, x7, x8;
  logic [2:0]       s;
  logic [WIDTH-1:0] f;
  logic             f_valid;
`ifdef MUX_8TO1_REG_PARITY_EN
  logic             f_par;
`endif

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Hand-computed sweep: with x1..x8 = 0..7 the selected word equals s.
  logic [2:0]       sweep_sel [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  logic [WIDTH-1:0] sweep_exp [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  logic             sweep_par [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  mux_8to1_reg #(
    .WIDTH(WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .x1     (x1),
    .x2     (x2),
    .x3     (x3),
    .x4     (x4),
    .x5     (x5),
    .x6     (x6),
    .x7     (x7),
    .x8     (x8),
    .s      (s),
`ifdef MUX_8TO1_REG_PARITY_EN
    .f_par  (f_par),
`endif
    .f      (f),
    .f_valid(f_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector just after a rising edge and step past the next edge.
  task automatic apply_stimulus(input logic e, input logic [2:0] sel,
                                input logic [WIDTH-1:0] exp_f, input logic exp_par,
                                input string name);
    exp_t item;
    en = e;
    s  = sel;
    if (e) begin
      item.name = name;
      item.f    = exp_f;
      item.par  = exp_par;
      exp_q.push_back(item);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_data();
    x1 = 3'd0; x2 = 3'd1; x3 = 3'd2; x4 = 3'd3;
    x5 = 3'd4; x6 = 3'd5; x7 = 3'd6; x8 = 3'd7;
  endtask

  // Monitor: every valid output must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t item;
    if (rst_n === 1'b1 && f_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_valid: got f=%0d with no pending vector, required none", f);
      end else begin
        item = exp_q.pop_front();
        check_output(item.name, 32'(f), 32'(item.f));
`ifdef MUX_8TO1_REG_PARITY_EN
        check_output({item.name, "_par"}, 32'(f_par), 32'(item.par));
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    s     = 3'd0;
    set_default_data();

    // Reset state
    #12;
    check_output("reset_f", 32'(f), 32'd0);
    check_output("reset_valid", 32'(f_valid), 32'd0);
`ifdef MUX_8TO1_REG_PARITY_EN
    check_output("reset_par", 32'(f_par), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset with f previously 5
    apply_stimulus(1'b1, 3'd5, 3'd5, 1'b0, "pre_reset_5");
    @(negedge clk);
    #1;
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_f", 32'(f), 32'd0);
    check_output("async_reset_valid", 32'(f_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exhaustive select sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, sweep_sel[i], sweep_exp[i], sweep_par[i], "sweep");
      check_output("sweep_valid", 32'(f_valid), 32'd1);
    end

    // Hold with en low, then re-enable
    apply_stimulus(1'b1, 3'd2, 3'd2, 1'b1, "hold_load_2");
    apply_stimulus(1'b0, 3'd6, 3'd0, 1'b0, "hold");
    check_output("hold_f", 32'(f), 32'd2);
    check_output("hold_valid", 32'(f_valid), 32'd0);
    apply_stimulus(1'b1, 3'd6, 3'd6, 1'b0, "reenable_6");

    // Data change under a fixed select; other inputs must not matter
    apply_stimulus(1'b1, 3'd3, 3'd3, 1'b0, "x4_before");
    x4 = 3'd5;
    x1 = 3'd7; x2 = 3'd6; x3 = 3'd1; x5 = 3'd2; x6 = 3'd0; x7 = 3'd4; x8 = 3'd3;
    apply_stimulus(1'b1, 3'd3, 3'd5, 1'b0, "x4_after");
    set_default_data();

    // Reset mid-stream: an edge under reset must not capture
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, sweep_sel[i], sweep_exp[i], sweep_par[i], "resweep");
      if (i == 3) begin
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("midstream_reset_f", 32'(f), 32'd0);
        check_output("midstream_reset_valid", 32'(f_valid), 32'd0);
        @(posedge clk);
        #1;
        check_output("reset_held_f", 32'(f), 32'd0);
        en    = 1'b0;
        rst_n = 1'b1;
      end
    end

    // Parity pattern words
    apply_stimulus(1'b1, 3'd7, 3'd7, 1'b1, "par_x8");
    apply_stimulus(1'b1, 3'd3, 3'd3, 1'b0, "par_x4");

    // Drain and verify every expectation was consumed
    apply_stimulus(1'b0, 3'd0, 3'd0, 1'b0, "idle");
    check_output("idle_hold_f", 32'(f), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    check_output("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mux_8to1_reg
